// File: rtl/oc8051_hex_loader_pkg.sv
// Shared definitions for the Intel-HEX program loader.
//   - hex_state_e : loader FSM state encoding
//   - HEX_DATA / HEX_EOF : record type codes the loader understands
//   - ASCII_COLON : record start character
package oc8051_hex_loader_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LEN,
        ST_ADDR_H,
        ST_ADDR_L,
        ST_TYPE,
        ST_DATA,
        ST_CSUM,
        ST_WRITE,
        ST_DONE
    } hex_state_e;

    localparam logic [7:0] HEX_DATA    = 8'h00;
    localparam logic [7:0] HEX_EOF     = 8'h01;
    localparam logic [7:0] ASCII_COLON = 8'h3A;

endpackage

// File: rtl/oc8051_hex_loader_nibble.sv
// Combinational ASCII to hex-nibble decoder.
//   ascii  : input character
//   nibble : decoded value 0..15 (0 when not a hex digit)
//   valid  : ascii is one of 0-9, A-F, a-f
module oc8051_hex_nibble (
    input  logic [7:0] ascii,
    output logic [3:0] nibble,
    output logic       valid
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the
        // block leaves it unassigned, which would otherwise infer a latch.
        nibble = 4'h0;
        valid  = 1'b0;
        if (ascii >= 8'h30 && ascii <= 8'h39) begin
            nibble = ascii[3:0];
            valid  = 1'b1;
        end else if ((ascii >= 8'h41 && ascii <= 8'h46) ||
                     (ascii >= 8'h61 && ascii <= 8'h66)) begin
            // 'A'/'a' have low nibble 1, so adding 9 yields 10..15.
            nibble = ascii[3:0] + 4'd9;
            valid  = 1'b1;
        end
    end

endmodule

// File: rtl/oc8051_hex_loader.sv
// Intel-HEX loader: parses ':' LL AAAA TT DD..DD CC records from an ASCII
// stream, verifies the checksum, buffers the data bytes and then writes
// them to program memory one byte per cycle. Holds the core in reset
// until an EOF record has been accepted.
//   clk, rst           : clock, asynchronous active-high reset
//   rx_data/rx_valid   : ASCII character input
//   rx_ready           : character accepted this cycle (low only while writing)
//   wr_en/wr_addr/wr_data : program-memory write port
//   busy               : inside a record (not IDLE or DONE)
//   done               : EOF record accepted (sticky until rst)
//   err                : some record was rejected (sticky until rst)
//   cpu_rst            : core reset request, the inverse of done
module oc8051_hex_loader
    import oc8051_hex_loader_pkg::*;
#(
    parameter int MAX_LEN = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        wr_en,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        cpu_rst
);

    localparam int         IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    hex_state_e  state_q, state_d;
    logic        nib_phase_q, nib_phase_d;   // 0: expecting high nibble
    logic [3:0]  hi_nib_q, hi_nib_d;
    logic [7:0]  sum_q, sum_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  type_q, type_d;
    logic [7:0]  idx_q, idx_d;
    logic [15:0] addr_q, addr_d;
    logic        wr_en_q, wr_en_d;
    logic [15:0] wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        err_q, err_d;

    logic [7:0]  rec_buf [MAX_LEN];

    logic [3:0]  nib;
    logic        nib_valid;

    oc8051_hex_nibble u_nibble (
        .ascii  (rx_data),
        .nibble (nib),
        .valid  (nib_valid)
    );

    logic       take;
    logic       in_field;
    logic       byte_done;
    logic       bad_char;
    logic       is_colon;
    logic [7:0] field_byte;
    logic [7:0] sum_next;
    logic       rec_data_ok;
    logic       rec_eof_ok;
    logic       last_data;
    logic       write_last;

    assign take        = rx_valid && rx_ready;
    assign in_field    = (state_q == ST_LEN)    || (state_q == ST_ADDR_H) ||
                         (state_q == ST_ADDR_L) || (state_q == ST_TYPE)   ||
                         (state_q == ST_DATA)   || (state_q == ST_CSUM);
    assign is_colon    = (rx_data == ASCII_COLON);
    // A ':' inside a record is not a hex digit, so it lands here too.
    assign bad_char    = take && in_field && !nib_valid;
    assign byte_done   = take && in_field && nib_valid && nib_phase_q;
    assign field_byte  = {hi_nib_q, nib};
    assign sum_next    = sum_q + field_byte;
    assign rec_data_ok = (sum_next == 8'h00) && (type_q == HEX_DATA);
    assign rec_eof_ok  = (sum_next == 8'h00) && (type_q == HEX_EOF);
    assign last_data   = (idx_q == len_q - 8'd1);
    assign write_last  = (idx_q == len_q);

    // State register and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // flop samples its _d value from before this clock edge.
        if (rst) begin
            state_q     <= ST_IDLE;
            nib_phase_q <= 1'b0;
            hi_nib_q    <= 4'h0;
            sum_q       <= 8'h00;
            len_q       <= 8'h00;
            type_q      <= 8'h00;
            idx_q       <= 8'h00;
            addr_q      <= 16'h0000;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= 16'h0000;
            wr_data_q   <= 8'h00;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            nib_phase_q <= nib_phase_d;
            hi_nib_q    <= hi_nib_d;
            sum_q       <= sum_d;
            len_q       <= len_d;
            type_q      <= type_d;
            idx_q       <= idx_d;
            addr_q      <= addr_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            err_q       <= err_d;
        end
    end

    // NOTE: the record buffer has no reset; a slot is always written in
    // DATA before WRITE can read it, so its power-up contents never leak.
    always_ff @(posedge clk) begin
        if (byte_done && state_q == ST_DATA) begin
            rec_buf[idx_q[IDX_W-1:0]] <= field_byte;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (take && is_colon) state_d = ST_LEN;
            end
            ST_LEN, ST_ADDR_H, ST_ADDR_L, ST_TYPE, ST_DATA, ST_CSUM: begin
                if (bad_char) begin
                    state_d = ST_IDLE;
                end else if (byte_done) begin
                    case (state_q)
                        ST_LEN:    state_d = (field_byte > MAX_LEN_B) ? ST_IDLE : ST_ADDR_H;
                        ST_ADDR_H: state_d = ST_ADDR_L;
                        ST_ADDR_L: state_d = ST_TYPE;
                        ST_TYPE:   state_d = (len_q != 8'h00) ? ST_DATA : ST_CSUM;
                        ST_DATA:   state_d = last_data ? ST_CSUM : ST_DATA;
                        ST_CSUM: begin
                            if (rec_data_ok)     state_d = (len_q != 8'h00) ? ST_WRITE : ST_IDLE;
                            else if (rec_eof_ok) state_d = ST_DONE;
                            else                 state_d = ST_IDLE;
                        end
                        default:   state_d = ST_IDLE;
                    endcase
                end
            end
            ST_WRITE: begin
                if (write_last) state_d = ST_IDLE;
            end
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and registered-output logic.
    always_comb begin
        nib_phase_d = nib_phase_q;
        hi_nib_d    = hi_nib_q;
        sum_d       = sum_q;
        len_d       = len_q;
        type_d      = type_q;
        idx_d       = idx_q;
        addr_d      = addr_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        err_d       = err_q;

        if (state_q == ST_IDLE && take && is_colon) begin
            sum_d       = 8'h00;
            idx_d       = 8'h00;
            nib_phase_d = 1'b0;
        end

        if (take && in_field && nib_valid) begin
            if (!nib_phase_q) begin
                hi_nib_d    = nib;
                nib_phase_d = 1'b1;
            end else begin
                nib_phase_d = 1'b0;
                sum_d       = sum_next;
                case (state_q)
                    ST_LEN:    len_d         = field_byte;
                    ST_ADDR_H: addr_d[15:8]  = field_byte;
                    ST_ADDR_L: addr_d[7:0]   = field_byte;
                    ST_TYPE:   type_d        = field_byte;
                    ST_DATA:   idx_d         = idx_q + 8'd1;
                    default: ;
                endcase
            end
        end

        if (bad_char) err_d = 1'b1;
        if (byte_done && state_q == ST_LEN && field_byte > MAX_LEN_B) err_d = 1'b1;
        if (byte_done && state_q == ST_CSUM && !rec_data_ok && !rec_eof_ok) err_d = 1'b1;

        // The first write is launched from the CC character itself so that
        // wr_en is high in the cycle right after CC is accepted.
        if (byte_done && state_q == ST_CSUM && rec_data_ok && len_q != 8'h00) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = rec_buf[0];
            idx_d     = 8'd1;
        end

        if (state_q == ST_WRITE && !write_last) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q + {8'h00, idx_q};
            wr_data_d = rec_buf[idx_q[IDX_W-1:0]];
            idx_d     = idx_q + 8'd1;
        end
    end

    assign rx_ready = (state_q != ST_WRITE);
    assign busy     = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done     = (state_q == ST_DONE);
    assign cpu_rst  = !done;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign err      = err_q;

endmodule

// File: tb/tb_oc8051_hex_loader.sv
module tb_oc8051_hex_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic        busy;
    logic        done;
    logic        err;
    logic        cpu_rst;

    always #5 clk = ~clk;

    oc8051_hex_loader #(.MAX_LEN(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .cpu_rst  (cpu_rst)
    );

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t        exp_q[$];
    wr_t        mon_e;
    int         vectors    = 0;
    int         miscompares = 0;
    bit         exp_err    = 1'b0;
    bit         exp_done   = 1'b0;
    bit         gap_en     = 1'b1;
    logic [7:0] rec_data [0:31];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst && wr_en) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: got addr %h data %h, expected no write", wr_addr, wr_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", {16'h0, wr_addr}, {16'h0, mon_e.addr});
                check("wr_data", {24'h0, wr_data}, {24'h0, mon_e.data});
            end
        end
    end

    // Called at a negedge; returns at the negedge after the character was accepted.
    task automatic send_char(input logic [7:0] c, output int stalls);
        stalls = 0;
        if (gap_en && $urandom_range(0, 3) == 0) begin
            rx_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        rx_data  = c;
        rx_valid = 1'b1;
        while (!rx_ready && stalls < 1000) begin
            @(negedge clk);
            stalls++;
        end
        if (!rx_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL rx_ready_timeout: got rx_ready 0 for %0d cycles, expected 1", stalls);
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        int st;
        for (int i = 0; i < s.len(); i++) send_char(s[i], st);
    endtask

    function automatic logic [7:0] hex_ch(input logic [3:0] n, input bit lower);
        if (n < 4'd10) return 8'h30 + {4'h0, n};
        return (lower ? 8'h61 : 8'h41) + {4'h0, n - 4'd10};
    endfunction

    // mode 0: uppercase, 1: lowercase, 2: random per digit
    task automatic send_hex(input logic [7:0] b, input int mode);
        int st;
        send_char(hex_ch(b[7:4], mode == 2 ? bit'($urandom_range(0, 1)) : bit'(mode)), st);
        send_char(hex_ch(b[3:0], mode == 2 ? bit'($urandom_range(0, 1)) : bit'(mode)), st);
    endtask

    // Reference model + stimulus for one record whose data bytes are in rec_data.
    task automatic send_record(input logic [7:0] len, input logic [15:0] addr,
                               input logic [7:0] typ, input logic [7:0] cs_xor,
                               input int mode, input bit with_colon);
        logic [7:0] sum;
        logic [7:0] cs;
        int         n;
        int         st;
        bit         ok;
        wr_t        w;
        n   = (len > 8'd31) ? 31 : int'(len);
        sum = len + addr[15:8] + addr[7:0] + typ;
        for (int i = 0; i < n; i++) sum = sum + rec_data[i];
        cs  = (8'h00 - sum) ^ cs_xor;
        ok  = (len <= 8'd16) && (typ == 8'h00 || typ == 8'h01) && (cs_xor == 8'h00);
        if (!exp_done) begin
            if (!ok) exp_err = 1'b1;
            else if (typ == 8'h01) exp_done = 1'b1;
            else begin
                for (int i = 0; i < n; i++) begin
                    w.addr = addr + 16'(i);
                    w.data = rec_data[i];
                    exp_q.push_back(w);
                end
            end
        end
        if (with_colon) send_char(8'h3A, st);
        send_hex(len, mode);
        send_hex(addr[15:8], mode);
        send_hex(addr[7:0], mode);
        send_hex(typ, mode);
        for (int i = 0; i < n; i++) send_hex(rec_data[i], mode);
        send_hex(cs, mode);
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_err"},     {31'h0, err},     {31'h0, exp_err});
        check({tag, "_done"},    {31'h0, done},    {31'h0, exp_done});
        check({tag, "_cpu_rst"}, {31'h0, cpu_rst}, {31'h0, !exp_done});
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!rx_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("drain_ready", {31'h0, rx_ready}, 32'h1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rx_ready"}, {31'h0, rx_ready}, 32'h1);
        check({tag, "_wr_en"},    {31'h0, wr_en},    32'h0);
        check({tag, "_wr_addr"},  {16'h0, wr_addr},  32'h0);
        check({tag, "_wr_data"},  {24'h0, wr_data},  32'h0);
        check({tag, "_busy"},     {31'h0, busy},     32'h0);
        check({tag, "_done"},     {31'h0, done},     32'h0);
        check({tag, "_err"},      {31'h0, err},      32'h0);
        check({tag, "_cpu_rst"},  {31'h0, cpu_rst},  32'h1);
    endtask

    task automatic pulse_reset();
        wait_ready();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_err  = 1'b0;
        exp_done = 1'b0;
    endtask

    initial begin
        int         st;
        logic [7:0] len;
        logic [7:0] typ;
        logic [7:0] csx;
        logic [15:0] addr;
        logic [7:0] junk [0:4];
        wr_t        w;

        junk[0] = 8'h0D; junk[1] = 8'h0A; junk[2] = 8'h20; junk[3] = 8'h78; junk[4] = 8'h51;
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        @(negedge clk);

        // Basic record, write timing and count.
        rec_data[0] = 8'h02; rec_data[1] = 8'h00; rec_data[2] = 8'h19;
        send_record(8'h03, 16'h0000, 8'h00, 8'h00, 0, 1'b1);
        check("first_write_latency", {31'h0, wr_en}, 32'h1);
        check("ready_low_in_write",  {31'h0, rx_ready}, 32'h0);
        check("busy_in_write",       {31'h0, busy}, 32'h1);
        @(negedge clk);
        check("write_cycle2", {31'h0, wr_en}, 32'h1);
        @(negedge clk);
        check("write_cycle3", {31'h0, wr_en}, 32'h1);
        @(negedge clk);
        check("write_count_end",      {31'h0, wr_en}, 32'h0);
        check("ready_after_last_wr",  {31'h0, rx_ready}, 32'h1);
        check_flags("basic");

        // Lowercase hex digits.
        for (int i = 0; i < 3; i++) begin
            w.addr = 16'(i);
            w.data = rec_data[i];
            exp_q.push_back(w);
        end
        send_str(":03000000020019e2");
        wait_ready();
        check_flags("lower");

        // Address wrap past FFFF.
        rec_data[0] = 8'hAA; rec_data[1] = 8'hBB;
        send_record(8'h02, 16'hFFFF, 8'h00, 8'h00, 2, 1'b1);
        wait_ready();
        check_flags("wrap");

        // rx_valid held with the next ':' during a 16-byte WRITE.
        gap_en = 1'b0;
        for (int i = 0; i < 16; i++) rec_data[i] = 8'($urandom);
        send_record(8'h10, 16'h1000, 8'h00, 8'h00, 0, 1'b1);
        send_char(8'h3A, st);
        check("write_stall_cycles", st, 32'd16);
        rec_data[0] = 8'hAA;
        send_record(8'h01, 16'h2000, 8'h00, 8'h00, 0, 1'b0);
        gap_en = 1'b1;
        wait_ready();
        check_flags("stall");

        // LL above MAX_LEN is rejected as soon as LEN completes.
        send_str(":1");
        check("err_before_len", {31'h0, err}, 32'h0);
        send_char(8'h31, st);
        exp_err = 1'b1;
        check("err_after_len", {31'h0, err}, 32'h1);
        check("idle_after_len", {31'h0, busy}, 32'h0);
        send_str("0000000000");

        // Reset in the middle of DATA.
        send_str(":0403000011");
        check("busy_mid_data", {31'h0, busy}, 32'h1);
        rst = 1'b1;
        #1;
        check_reset_values("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        exp_err = 1'b0;
        rec_data[0] = 8'h11; rec_data[1] = 8'h22; rec_data[2] = 8'h33; rec_data[3] = 8'h44;
        send_record(8'h04, 16'h0300, 8'h00, 8'h00, 2, 1'b1);
        wait_ready();
        check_flags("after_rst");

        // Unsupported record type with a valid sum.
        send_str(":00000002FE");
        exp_err = 1'b1;
        check_flags("type02");
        check("type02_idle", {31'h0, busy}, 32'h0);

        // Bad checksum, then a valid record still commits.
        pulse_reset();
        send_str(":03000000020019E3");
        exp_err = 1'b1;
        check_flags("bad_sum");
        rec_data[0] = 8'h5A;
        send_record(8'h01, 16'h0400, 8'h00, 8'h00, 0, 1'b1);
        wait_ready();
        check_flags("after_bad_sum");

        // Non-hex character inside a record.
        pulse_reset();
        send_str(":03G");
        exp_err = 1'b1;
        check_flags("nonhex");

        // ':' inside a record is an error, not a restart.
        pulse_reset();
        send_str(":00:03000000020019E2");
        exp_err = 1'b1;
        wait_ready();
        check_flags("colon_inside");

        // Randomized records with junk between them.
        pulse_reset();
        for (int r = 0; r < 30; r++) begin
            repeat ($urandom_range(0, 2)) send_char(junk[$urandom_range(0, 4)], st);
            len  = ($urandom_range(0, 7) == 0) ? 8'(17 + $urandom_range(0, 3)) : 8'($urandom_range(0, 16));
            addr = ($urandom_range(0, 3) == 0) ? 16'hFFF0 + 16'($urandom_range(0, 15)) : 16'($urandom);
            typ  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(2, 5)) : 8'h00;
            csx  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            for (int i = 0; i < 31; i++) rec_data[i] = 8'($urandom);
            send_record(len, addr, typ, csx, 2, 1'b1);
            check_flags("random");
        end
        wait_ready();

        // EOF record.
        send_record(8'h00, 16'h0000, 8'h01, 8'h00, 0, 1'b1);
        check_flags("eof");
        check("eof_busy", {31'h0, busy}, 32'h0);

        // After DONE everything is discarded.
        rec_data[0] = 8'h77;
        send_record(8'h01, 16'h0500, 8'h00, 8'h00, 0, 1'b1);
        send_str(":zz\r\n");
        check("done_ready", {31'h0, rx_ready}, 32'h1);
        check_flags("post_done");

        repeat (4) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
